// File: rtl/cmt_pkg.sv
// Shared definitions for the compare-match timer APB initiator:
// FSM state encoding and default bus widths.
package cmt_pkg;

    localparam int CMT_AW = 8;
    localparam int CMT_DW = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b10
    } cmt_apb_state_e;

endpackage : cmt_pkg

// File: rtl/cmt_apb_tmo.sv
// Wait-state timeout counter: cleared on SETUP, counts ACCESS cycles with
// pready low and flags expiry once it has reached TMO-1.
module cmt_apb_tmo #(
    parameter int TMO = 16,
    parameter int TW  = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam logic [TW-1:0] LAST = TW'(TMO - 1);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    // Holding at LAST keeps the count bounded without a wrap check.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == LAST);

endmodule : cmt_apb_tmo

// File: rtl/cmt_apb_master.sv
// Single-outstanding request/response to APB initiator with registered APB
// outputs, wait-state support and a timeout abort reported as an error.
module cmt_apb_master
    import cmt_pkg::*;
#(
    parameter int AW  = CMT_AW,
    parameter int DW  = CMT_DW,
    parameter int TMO = 16,
    parameter int TW  = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid_i,
    input  logic          req_write_i,
    input  logic [AW-1:0] req_addr_i,
    input  logic [DW-1:0] req_wdata_i,
    output logic          req_ready_o,
    output logic          rsp_valid_o,
    output logic [DW-1:0] rsp_rdata_o,
    output logic          rsp_err_o,
    output logic          psel_o,
    output logic          penable_o,
    output logic          pwrite_o,
    output logic [AW-1:0] paddr_o,
    output logic [DW-1:0] pwdata_o,
    input  logic [DW-1:0] prdata_i,
    input  logic          pready_i,
    input  logic          pslverr_i
);

    cmt_apb_state_e state_q, state_d;

    logic          psel_q, psel_d;
    logic          penable_q, penable_d;
    logic          pwrite_q, pwrite_d;
    logic [AW-1:0] paddr_q, paddr_d;
    logic [DW-1:0] pwdata_q, pwdata_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic          rsp_err_q, rsp_err_d;
    logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;

    logic tmo_clr;
    logic tmo_en;
    logic tmo_expire;

    assign tmo_clr = (state_q == SETUP);
    assign tmo_en  = (state_q == ACCESS) && !pready_i;

    cmt_apb_tmo #(
        .TMO (TMO),
        .TW  (TW)
    ) u_tmo (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (tmo_clr),
        .en_i     (tmo_en),
        .expire_o (tmo_expire)
    );

    always_comb begin
        state_d     = state_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;

        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    pwrite_d = req_write_i;
                    paddr_d  = req_addr_i;
                    pwdata_d = req_wdata_i;
                    psel_d   = 1'b1;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
            end
            ACCESS: begin
                // A ready slave wins over an expiring counter in the same cycle.
                if (pready_i) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = pslverr_i;
                    rsp_rdata_d = pwrite_q ? '0 : prdata_i;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    state_d     = IDLE;
                end else if (tmo_expire) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign req_ready_o = (state_q == IDLE);
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;
    assign psel_o      = psel_q;
    assign penable_o   = penable_q;
    assign pwrite_o    = pwrite_q;
    assign paddr_o     = paddr_q;
    assign pwdata_o    = pwdata_q;

endmodule : cmt_apb_master

// File: tb/tb_cmt_apb_master.sv
// Self-checking bench for cmt_apb_master: scenario tasks with a response
// scoreboard, latency, APB stability, timeout and reset checks.
module tb_cmt_apb_master;

    localparam int AW  = 8;
    localparam int DW  = 32;
    localparam int TMO = 16;
    localparam int TW  = 5;

    typedef struct packed {
        logic [DW-1:0] rdata;
        logic          err;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid_i;
    logic          req_write_i;
    logic [AW-1:0] req_addr_i;
    logic [DW-1:0] req_wdata_i;
    logic          req_ready_o;
    logic          rsp_valid_o;
    logic [DW-1:0] rsp_rdata_o;
    logic          rsp_err_o;
    logic          psel_o;
    logic          penable_o;
    logic          pwrite_o;
    logic [AW-1:0] paddr_o;
    logic [DW-1:0] pwdata_o;
    logic [DW-1:0] prdata_i;
    logic          pready_i;
    logic          pslverr_i;

    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];

    cmt_apb_master #(
        .AW  (AW),
        .DW  (DW),
        .TMO (TMO),
        .TW  (TW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid_i (req_valid_i),
        .req_write_i (req_write_i),
        .req_addr_i  (req_addr_i),
        .req_wdata_i (req_wdata_i),
        .req_ready_o (req_ready_o),
        .rsp_valid_o (rsp_valid_o),
        .rsp_rdata_o (rsp_rdata_o),
        .rsp_err_o   (rsp_err_o),
        .psel_o      (psel_o),
        .penable_o   (penable_o),
        .pwrite_o    (pwrite_o),
        .paddr_o     (paddr_o),
        .pwdata_o    (pwdata_o),
        .prdata_i    (prdata_i),
        .pready_i    (pready_i),
        .pslverr_i   (pslverr_i)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one transfer; slave raises pready on ACCESS cycle rdy_cyc (0 = never).
    // lat counts rising edges from the acceptance edge (1) to the edge raising rsp_valid_o.
    task automatic run_txn(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                           input int rdy_cyc, input logic [DW-1:0] rd, input logic se,
                           output int lat, output int acc, output logic stable, output logic got,
                           output logic psel_at_rsp, output logic [DW-1:0] o_rdata, output logic o_err);
        int guard;
        req_write_i = wr;
        req_addr_i  = a;
        req_wdata_i = wd;
        req_valid_i = 1'b1;
        pready_i    = 1'b0;
        prdata_i    = ~rd;
        pslverr_i   = ~se;
        guard = 0;
        while (!req_ready_o && guard < 50) begin
            tick();
            guard++;
        end
        tick();
        req_valid_i = 1'b0;
        lat    = 1;
        acc    = 0;
        stable = 1'b1;
        while (!rsp_valid_o && lat < TMO + 10) begin
            if (psel_o !== 1'b1 || paddr_o !== a || pwrite_o !== wr || (wr && pwdata_o !== wd))
                stable = 1'b0;
            if (penable_o === 1'b1) acc++;
            if (penable_o === 1'b1 && rdy_cyc != 0 && acc >= rdy_cyc) begin
                pready_i  = 1'b1;
                prdata_i  = rd;
                pslverr_i = se;
            end else begin
                pready_i  = 1'b0;
                prdata_i  = ~rd;
                pslverr_i = ~se;
            end
            tick();
            lat++;
        end
        got         = rsp_valid_o;
        psel_at_rsp = psel_o;
        o_rdata     = rsp_rdata_o;
        o_err       = rsp_err_o;
        pready_i    = 1'b0;
        pslverr_i   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid_i = 1'b1; req_write_i = 1'b1; req_addr_i = 8'hFF; req_wdata_i = '1;
        pready_i = 1'b1; pslverr_i = 1'b1; prdata_i = '1;
        tick();
        tick();
        checks++;
        if ({psel_o, penable_o, pwrite_o, rsp_valid_o, rsp_err_o} !== 5'b0)
            $display("FAIL reset_ctrl: got %b want 00000", {psel_o, penable_o, pwrite_o, rsp_valid_o, rsp_err_o});
        checks++;
        if (paddr_o !== '0 || pwdata_o !== '0 || rsp_rdata_o !== '0) begin
            errors++;
            $display("FAIL reset_data: paddr=%h pwdata=%h rdata=%h want all 0", paddr_o, pwdata_o, rsp_rdata_o);
        end
        if ({psel_o, penable_o, pwrite_o, rsp_valid_o, rsp_err_o} !== 5'b0) errors++;
        checks++;
        if (req_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b want 1", req_ready_o);
        end
        req_valid_i = 1'b0; pready_i = 1'b0; pslverr_i = 1'b0;
        rst = 1'b0;
        tick();
        $display("txn reset: outputs cleared");
    endtask

    task automatic test_write_zero_wait();
        int lat, acc; logic st, got, ps, er; logic [DW-1:0] rd; exp_t e;
        exp_q.push_back('{rdata: 32'h0, err: 1'b0});
        run_txn(1'b1, 8'h04, 32'hDEADBEEF, 1, 32'h5555AAAA, 1'b0, lat, acc, st, got, ps, rd, er);
        e = exp_q.pop_front();
        checks++;
        if (got !== 1'b1 || lat != 3) begin
            errors++;
            $display("FAIL wr0_latency: got valid=%b lat=%0d want valid=1 lat=3", got, lat);
        end
        checks++;
        if (st !== 1'b1 || acc != 1) begin
            errors++;
            $display("FAIL wr0_apb: stable=%b access_cycles=%0d want 1 and 1", st, acc);
        end
        checks++;
        if (rd !== e.rdata || er !== e.err) begin
            errors++;
            $display("FAIL wr0_rsp: rdata=%h err=%b want %h %b", rd, er, e.rdata, e.err);
        end
        $display("txn write a=04 d=DEADBEEF lat=%0d err=%b", lat, er);
    endtask

    task automatic test_read_wait();
        int lat, acc; logic st, got, ps, er; logic [DW-1:0] rd; exp_t e;
        exp_q.push_back('{rdata: 32'h12345678, err: 1'b0});
        run_txn(1'b0, 8'h08, 32'h0, 3, 32'h12345678, 1'b0, lat, acc, st, got, ps, rd, er);
        e = exp_q.pop_front();
        checks++;
        if (got !== 1'b1 || lat != 5 || acc != 3) begin
            errors++;
            $display("FAIL rd2_latency: valid=%b lat=%0d acc=%0d want 1 5 3", got, lat, acc);
        end
        checks++;
        if (st !== 1'b1) begin
            errors++;
            $display("FAIL rd2_addr_stable: got %b want 1", st);
        end
        checks++;
        if (rd !== e.rdata || er !== e.err) begin
            errors++;
            $display("FAIL rd2_rsp: rdata=%h err=%b want %h %b", rd, er, e.rdata, e.err);
        end
        $display("txn read a=08 waits=2 lat=%0d rdata=%h", lat, rd);
    endtask

    task automatic test_slverr();
        int lat, acc; logic st, got, ps, er; logic [DW-1:0] rd; exp_t e;
        exp_q.push_back('{rdata: 32'hCAFEF00D, err: 1'b1});
        run_txn(1'b0, 8'h0C, 32'h0, 1, 32'hCAFEF00D, 1'b1, lat, acc, st, got, ps, rd, er);
        e = exp_q.pop_front();
        checks++;
        if (got !== 1'b1 || lat != 3 || rd !== e.rdata || er !== e.err) begin
            errors++;
            $display("FAIL slverr_rsp: valid=%b lat=%0d rdata=%h err=%b want 1 3 %h %b", got, lat, rd, er, e.rdata, e.err);
        end
        tick();
        checks++;
        if (rsp_valid_o !== 1'b0 || rsp_err_o !== 1'b1) begin
            errors++;
            $display("FAIL slverr_pulse: valid=%b err=%b want 0 1", rsp_valid_o, rsp_err_o);
        end
        $display("txn read a=0C slverr err=%b", er);
    endtask

    task automatic test_timeout();
        int lat, acc; logic st, got, ps, er; logic [DW-1:0] rd; exp_t e;
        exp_q.push_back('{rdata: 32'h0, err: 1'b1});
        run_txn(1'b0, 8'h10, 32'h0, 0, 32'h77777777, 1'b0, lat, acc, st, got, ps, rd, er);
        e = exp_q.pop_front();
        checks++;
        if (got !== 1'b1 || acc != TMO || lat != TMO + 2) begin
            errors++;
            $display("FAIL tmo_cycles: valid=%b acc=%0d lat=%0d want 1 %0d %0d", got, acc, lat, TMO, TMO + 2);
        end
        checks++;
        if (ps !== 1'b0 || rd !== e.rdata || er !== e.err) begin
            errors++;
            $display("FAIL tmo_rsp: psel=%b rdata=%h err=%b want 0 %h %b", ps, rd, er, e.rdata, e.err);
        end
        tick();
        $display("txn read a=10 timeout acc=%0d err=%b", acc, er);
    endtask

    task automatic test_timeout_late_ready();
        int lat, acc; logic st, got, ps, er; logic [DW-1:0] rd; exp_t e;
        exp_q.push_back('{rdata: 32'hA5A5C3C3, err: 1'b0});
        run_txn(1'b0, 8'h14, 32'h0, TMO, 32'hA5A5C3C3, 1'b0, lat, acc, st, got, ps, rd, er);
        e = exp_q.pop_front();
        checks++;
        if (got !== 1'b1 || acc != TMO || rd !== e.rdata || er !== e.err) begin
            errors++;
            $display("FAIL tmo_late_ready: valid=%b acc=%0d rdata=%h err=%b want 1 %0d %h %b", got, acc, rd, er, TMO, e.rdata, e.err);
        end
        tick();
        $display("txn read a=14 ready on cycle %0d rdata=%h err=%b", TMO, rd, er);
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] addrs [3];
        int accepted, seen, gap, cyc, bad_gap, in_gap, had_sel;
        exp_t e;
        addrs[0] = 8'h20; addrs[1] = 8'h24; addrs[2] = 8'h28;
        accepted = 0; seen = 0; bad_gap = 0; gap = 0; in_gap = 0; had_sel = 0;
        req_write_i = 1'b1;
        req_addr_i  = addrs[0];
        req_wdata_i = 32'h1000_0000;
        req_valid_i = 1'b1;
        pready_i    = 1'b1;
        prdata_i    = 32'hFFFF0000;
        for (cyc = 0; cyc < 40 && seen < 3; cyc++) begin
            pslverr_i = (paddr_o == 8'h24);
            if (req_ready_o && req_valid_i) begin
                exp_q.push_back('{rdata: 32'h0, err: (addrs[accepted] == 8'h24)});
                accepted++;
            end
            tick();
            if (accepted < 3) begin
                req_addr_i  = addrs[accepted];
                req_wdata_i = 32'h1000_0000 + accepted;
            end else begin
                req_valid_i = 1'b0;
            end
            if (psel_o) begin
                if (in_gap && gap != 1) bad_gap++;
                in_gap = 0; gap = 0; had_sel = 1;
            end else if (had_sel && seen < 2) begin
                in_gap = 1; gap++;
            end
            if (rsp_valid_o) begin
                seen++;
                e = exp_q.pop_front();
                checks++;
                if (rsp_err_o !== e.err || rsp_rdata_o !== e.rdata) begin
                    errors++;
                    $display("FAIL b2b_rsp%0d: err=%b rdata=%h want %b %h", seen, rsp_err_o, rsp_rdata_o, e.err, e.rdata);
                end
                $display("txn b2b write #%0d err=%b", seen, rsp_err_o);
            end
        end
        checks++;
        if (seen != 3 || bad_gap != 0) begin
            errors++;
            $display("FAIL b2b_count_gap: responses=%0d bad_gaps=%0d want 3 0", seen, bad_gap);
        end
        req_valid_i = 1'b0; pready_i = 1'b0; pslverr_i = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_access();
        int guard, lat, acc; logic saw, st, got, ps, er; logic [DW-1:0] rd;
        req_write_i = 1'b0; req_addr_i = 8'h30; req_valid_i = 1'b1; pready_i = 1'b0;
        guard = 0;
        while (!req_ready_o && guard < 50) begin
            tick();
            guard++;
        end
        tick();
        req_valid_i = 1'b0;
        tick();
        tick();
        checks++;
        if (psel_o !== 1'b1 || penable_o !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_in_access: psel=%b penable=%b want 1 1", psel_o, penable_o);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (psel_o !== 1'b0 || penable_o !== 1'b0 || rsp_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_drop: psel=%b penable=%b valid=%b want 0 0 0", psel_o, penable_o, rsp_valid_o);
        end
        rst = 1'b0;
        saw = 1'b0;
        repeat (TMO + 4) begin
            tick();
            if (rsp_valid_o) saw = 1'b1;
        end
        checks++;
        if (saw !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_no_rsp: saw response=%b want 0", saw);
        end
        exp_q.push_back('{rdata: 32'h0, err: 1'b0});
        run_txn(1'b1, 8'h34, 32'h0BADC0DE, 2, 32'h11112222, 1'b0, lat, acc, st, got, ps, rd, er);
        checks++;
        if (got !== 1'b1 || lat != 4 || st !== 1'b1 || rd !== exp_q[0].rdata || er !== exp_q[0].err) begin
            errors++;
            $display("FAIL rstmid_fresh: valid=%b lat=%0d stable=%b rdata=%h err=%b want 1 4 1 0 0", got, lat, st, rd, er);
        end
        void'(exp_q.pop_front());
        $display("txn reset mid-access, fresh write lat=%0d err=%b", lat, er);
    endtask

    initial begin
        rst = 1'b1;
        req_valid_i = 1'b0; req_write_i = 1'b0; req_addr_i = '0; req_wdata_i = '0;
        prdata_i = '0; pready_i = 1'b0; pslverr_i = 1'b0;
        test_reset();
        test_write_zero_wait();
        test_read_wait();
        test_slverr();
        test_timeout();
        test_timeout_late_ready();
        test_back_to_back();
        test_reset_mid_access();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

endmodule : tb_cmt_apb_master

// File: doc/cmt_apb_master.md
Name: cmt_apb_master

Overview:
- APB initiator for the compare-match timer subsystem. Turns a simple single-outstanding request/response interface (from CPU-side bus glue or a test sequencer) into APB SETUP/ACCESS transfers toward cmt-family APB slaves.
- Registers every APB output and supports wait states via pready.
- Bounds wait states with a timeout counter. On expiry the transfer is aborted and reported as an error.

Parameters:
- AW, 8, address width (paddr_o, req_addr_i).
- DW, 32, data width.
- TMO, 16, maximum ACCESS cycles with pready_i low before abort. Must be ≥2.
- TW, 5, timeout counter width. Must satisfy 2^TW > TMO.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid_i  in  1  request present.
- req_write_i  in  1  1 = write, 0 = read.
- req_addr_i  in  AW  request address.
- req_wdata_i  in  DW  write data.
- req_ready_o  out  1  request accepted this cycle when high together with req_valid_i.
- rsp_valid_o  out  1  one-cycle completion pulse.
- rsp_rdata_o  out  DW  read data; valid with rsp_valid_o.
- rsp_err_o  out  1  pslverr_i or timeout; valid with rsp_valid_o.
- psel_o  out  1  APB select.
- penable_o  out  1  APB enable.
- pwrite_o  out  1  APB direction.
- paddr_o  out  AW  APB address.
- pwdata_o  out  DW  APB write data.
- prdata_i  in  DW  APB read data.
- pready_i  in  1  APB ready.
- pslverr_i  in  1  APB slave error.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst). While rst is high at a rising edge:
  - state = IDLE.
  - psel_o, penable_o, pwrite_o, rsp_valid_o and rsp_err_o = 0.
  - paddr_o, pwdata_o and rsp_rdata_o = 0.
  - Timeout counter = 0.
- Reset asserted mid-transfer drops psel_o/penable_o at the next edge. No response is issued for the aborted transfer.
- FSM states: IDLE, SETUP, ACCESS.
  - IDLE: req_ready_o = 1 (combinational from state only). On req_valid_i, latch write/addr/wdata into pwrite_o/paddr_o/pwdata_o, set psel_o = 1 and go to SETUP.
  - SETUP: psel_o = 1, penable_o = 0. Unconditionally go to ACCESS with penable_o = 1 and the counter cleared.
  - ACCESS: psel_o = 1, penable_o = 1. Each cycle pready_i is low, the counter increments.
    - pready_i = 1: transfer completes. Capture prdata_i into rsp_rdata_o on reads (writes leave rsp_rdata_o = 0). Set rsp_err_o = pslverr_i, pulse rsp_valid_o the following cycle, drop psel_o/penable_o and return to IDLE.
    - Counter reaches TMO-1 with pready_i still low: abort. Set rsp_valid_o = 1, rsp_err_o = 1, rsp_rdata_o = 0, drop psel_o/penable_o and return to IDLE.
    - pready_i high on the timeout cycle: completion takes priority over abort.
- req_ready_o = 0 in SETUP and ACCESS. Exactly one outstanding transfer.
- Minimum latency, zero wait states:
  - acceptance edge E0;
  - SETUP during cycle E0→E1;
  - ACCESS during E1→E2 with pready_i high;
  - rsp_valid_o high during E2→E3.
  - The next request can be accepted in the IDLE cycle that follows. That cycle is the same one in which rsp_valid_o is high.
- Each added wait cycle in ACCESS adds one cycle of latency.
- paddr_o, pwrite_o and pwdata_o hold stable from SETUP through the end of ACCESS, as APB requires. They retain their last values in IDLE.
- rsp_rdata_o and rsp_err_o hold until the next completion. rsp_valid_o is a single-cycle pulse.
- pslverr_i and prdata_i are ignored except in an ACCESS cycle with pready_i = 1.
- Counter arithmetic: unsigned TW bits. It saturates by construction because it is cleared on SETUP entry and never exceeds TMO-1.

Decomposition:
- Shared package cmt_pkg:
  - FSM state encoding constants: IDLE 2'b00, SETUP 2'b01, ACCESS 2'b10.
  - Default AW/DW.
- No sub-module is required. The wait-state timeout counter may optionally be split out as cmt_apb_tmo (clear/enable/expire).

Test Plan:
- Write, zero wait: req write addr 8'h04, data 32'hDEADBEEF, pready_i tied 1 → SETUP then ACCESS with paddr_o = 04 and pwdata_o = DEADBEEF. rsp_valid_o 3 cycles after acceptance with rsp_err_o = 0.
- Read, 2 wait states: read 8'h08, pready_i high on the 3rd ACCESS cycle, prdata_i = 32'h12345678 → rsp_rdata_o = 12345678, rsp_valid_o at acceptance+5; paddr_o stable throughout.
- Slave error: read 8'h0C with pready_i = 1 and pslverr_i = 1 → rsp_err_o = 1, rsp_valid_o one pulse.
- Timeout: read with pready_i held 0, TMO = 16 → exactly 16 ACCESS cycles, then psel_o = 0 and rsp_valid_o = 1 with rsp_err_o = 1, rsp_rdata_o = 0. Repeat with pready_i rising on the 16th cycle → normal completion, rsp_err_o = 0.
- Back-to-back: req_valid_i held high with 3 writes → each accepted only in IDLE. psel_o low exactly one cycle between transfers; 3 rsp_valid_o pulses in order.
- Reset mid-ACCESS: assert rst during a wait state → next edge psel_o = penable_o = 0, no rsp_valid_o. A fresh request after reset completes normally.
